dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_fmt.sv | 58 +++++
 rtl/dmem_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and encodings for the data-memory controller slice.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic {
      ST_IDLE,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatting: store byte-enables/replicated data, load
// extraction with sign/zero extension, and alignment checking.
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_lane,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata_sh,
   output logic        misalign,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_lane,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Sub-word data is replicated across lanes so the byte-enables alone pick the target bytes.
   always_comb begin
      st_be       = 4'b0000;
      st_wdata_sh = st_wdata;
      misalign    = 1'b0;
      case (st_size)
         SZ_BYTE: begin
            st_be       = 4'b0001 << st_lane;
            st_wdata_sh = {4{st_wdata[7:0]}};
         end
         SZ_HALF: begin
            st_be       = st_lane[1] ? 4'b1100 : 4'b0011;
            st_wdata_sh = {2{st_wdata[15:0]}};
            misalign    = st_lane[0];
         end
         SZ_WORD: begin
            st_be    = 4'b1111;
            misalign = |st_lane;
         end
         default: ;
      endcase
   end

   assign ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
   assign ld_half = ld_word[{ld_lane[1], 4'b0000} +: 16];

   always_comb begin
      ld_data = '0;
      case (ld_size)
         SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
         SZ_WORD: ld_data = ld_word;
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-port data memory with a valid/ready request/response handshake,
// byte/halfword/word accesses, fault detection and a saturating fault counter.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int ERR_CNT_W   = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [1:0]           req_size_i,
   input  logic                 req_unsigned_i,
   input  logic [31:0]          req_addr_i,
   input  logic [31:0]          req_wdata_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [31:0]          rsp_rdata_o,
   output logic                 rsp_err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_t        state;
   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic          accept;
   logic          range_err;
   logic          misalign;
   logic          fault;
   logic          wr_en;
   logic [3:0]    st_be;
   logic [31:0]   st_wdata_sh;
   logic [31:0]   ld_data;
   logic [31:0]   rd_word_p1;
   logic [1:0]    ld_size_p1;
   logic [1:0]    ld_lane_p1;
   logic          ld_uns_p1;
   logic          ld_ok_p1;
   logic          err_p1;
   rsp_t          rsp_c;

   assign accept    = req_valid_i & req_ready_o;
   assign idx       = req_addr_i[AW+1:2];
   assign range_err = (req_addr_i >> (AW + 2)) != '0;
   assign fault     = range_err | misalign | (req_size_i == SZ_RSVD);
   assign wr_en     = accept & req_we_i & ~fault;

   dmem_lane_fmt u_fmt (
      .st_size     (req_size_i),
      .st_lane     (req_addr_i[1:0]),
      .st_wdata    (req_wdata_i),
      .st_be       (st_be),
      .st_wdata_sh (st_wdata_sh),
      .misalign    (misalign),
      .ld_size     (ld_size_p1),
      .ld_lane     (ld_lane_p1),
      .ld_unsigned (ld_uns_p1),
      .ld_word     (rd_word_p1),
      .ld_data     (ld_data)
   );

   // p0 -> p1: array read and access attributes captured on the accept edge
   always_ff @(posedge clk_i) begin
      if (accept) begin
         rd_word_p1 <= mem[idx];
         ld_size_p1 <= req_size_i;
         ld_lane_p1 <= req_addr_i[1:0];
         ld_uns_p1  <= req_unsigned_i;
      end
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (st_be[b]) mem[idx][8*b +: 8] <= st_wdata_sh[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= ST_IDLE;
         req_ready_o <= 1'b1;
         rsp_valid_o <= 1'b0;
         err_p1      <= 1'b0;
         ld_ok_p1    <= 1'b0;
         err_cnt_o   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state       <= ST_RESP;
                  req_ready_o <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  err_p1      <= fault;
                  ld_ok_p1    <= ~fault & ~req_we_i;
                  if (fault && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  state       <= ST_IDLE;
                  req_ready_o <= 1'b1;
                  rsp_valid_o <= 1'b0;
                  err_p1      <= 1'b0;
                  ld_ok_p1    <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Faults and stores both return zero data; only a good load exposes the array word.
   assign rsp_c = '{err: err_p1, rdata: (ld_ok_p1 ? ld_data : 32'd0)};
   assign {rsp_err_o, rsp_rdata_o} = rsp_c;

endmodule
